// File: rtl/input_vc_if.sv
// Bundle of link, allocator and switch signals between one input VC controller and its
// neighbours. The master side is the upstream link plus the allocators; the slave side is the controller.
interface input_vc_if #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_DATA   = 32,
  parameter int PORT_SIZE   = 3
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  logic                 flit_valid_i;
  logic [1:0]           flit_type_i;
  logic [FLIT_DATA-1:0] flit_data_i;
  logic [PORT_SIZE-1:0] dest_port_i;
  logic                 vc_request_o;
  logic [PORT_SIZE-1:0] out_port_o;
  logic                 vc_valid_i;
  logic                 sa_request_o;
  logic                 sa_grant_i;
  logic                 flit_valid_o;
  logic [1:0]           flit_type_o;
  logic [FLIT_DATA-1:0] flit_data_o;
  logic                 idle_o;
  logic [CW-1:0]        count_o;
  logic                 error_o;
  logic [1:0]           state_dbg;

  modport master (
    output flit_valid_i, flit_type_i, flit_data_i, dest_port_i, vc_valid_i, sa_grant_i,
    input  vc_request_o, out_port_o, sa_request_o, flit_valid_o, flit_type_o, flit_data_o,
    input  idle_o, count_o, error_o, state_dbg
  );

  modport slave (
    input  flit_valid_i, flit_type_i, flit_data_i, dest_port_i, vc_valid_i, sa_grant_i,
    output vc_request_o, out_port_o, sa_request_o, flit_valid_o, flit_type_o, flit_data_o,
    output idle_o, count_o, error_o, state_dbg
  );
endinterface

// File: rtl/input_vc_controller.sv
// Input-port virtual channel: buffers flits, requests a VC for each packet head and
// forwards flits on switch grants; idle_o feeds the upstream allocator's availability input.
module input_vc_controller #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_DATA   = 32,
  parameter int PORT_SIZE   = 3
) (
  input logic        clk,
  input logic        rst,
  input_vc_if.slave  bus
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, VA = 2'd1, ACTIVE = 2'd2} state_t;

  // Handshakes: a flit is written on any edge with flit_valid_i high and is silently dropped
  // (raising error_o) if illegal; a pop happens only on an edge where sa_grant_i && sa_request_o.
  state_t               state, state_nxt;
  logic [1:0]           type_mem [BUFFER_SIZE];
  logic [FLIT_DATA-1:0] data_mem [BUFFER_SIZE];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic                 tail_written;
  logic                 is_head, head_ok, body_ok, push, pop, tail_pop, ret_idle, sa_request;
  logic                 idle_q, error_q, fvalid_q;
  logic [1:0]           ftype_q;
  logic [FLIT_DATA-1:0] fdata_q;
  logic [PORT_SIZE-1:0] port_q;

  always_comb begin
    is_head    = (bus.flit_type_i == 2'b00) || (bus.flit_type_i == 2'b11);
    head_ok    = is_head && (state == IDLE) && (count == '0);
    body_ok    = !is_head && ((state == VA) || (state == ACTIVE)) && !tail_written;
    push       = bus.flit_valid_i && (count != FULL) && (head_ok || body_ok);
    sa_request = (state == ACTIVE) && (count != '0);
    pop        = bus.sa_grant_i && sa_request;
    // TAIL (10) and HEADTAIL (11) both end a packet; bit 1 marks them.
    tail_pop   = pop && type_mem[rd_ptr][1];
    count_nxt  = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_nxt = state;
    ret_idle  = 1'b0;
    case (state)
      IDLE:    if (push) state_nxt = VA;
      VA:      if (bus.vc_valid_i) state_nxt = ACTIVE;
      ACTIVE: begin
        if (tail_pop) begin
          state_nxt = IDLE;
          ret_idle  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tail_written <= 1'b0;
      idle_q       <= 1'b1;
      error_q      <= 1'b0;
      fvalid_q     <= 1'b0;
      ftype_q      <= '0;
      fdata_q      <= '0;
      port_q       <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      idle_q   <= (state_nxt == IDLE) && (count_nxt == '0);
      fvalid_q <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        ftype_q <= type_mem[rd_ptr];
        fdata_q <= data_mem[rd_ptr];
      end
      if (push && head_ok) port_q <= bus.dest_port_i;
      if (bus.flit_valid_i && !push) error_q <= 1'b1;
      if (ret_idle) tail_written <= 1'b0;
      else if (push && bus.flit_type_i[1]) tail_written <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr] <= bus.flit_type_i;
      data_mem[wr_ptr] <= bus.flit_data_i;
    end
  end

  assign bus.vc_request_o = (state == VA);
  assign bus.sa_request_o = sa_request;
  assign bus.out_port_o   = port_q;
  assign bus.flit_valid_o = fvalid_q;
  assign bus.flit_type_o  = ftype_q;
  assign bus.flit_data_o  = fdata_q;
  assign bus.idle_o       = idle_q;
  assign bus.count_o      = count;
  assign bus.error_o      = error_q;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_input_vc_controller.sv
// Bench for input_vc_controller: vector table for single/multi-flit packets, then hand-written
// sequences for overflow, protocol errors, concurrent push/pop with wrap, and mid-packet reset.
module tb_input_vc_controller;
  localparam int W = 34;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_vc_if #(.BUFFER_SIZE(8), .FLIT_DATA(32), .PORT_SIZE(3)) bus ();

  input_vc_controller #(.BUFFER_SIZE(8), .FLIT_DATA(32), .PORT_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic        fv;
    logic [1:0]  ty;
    logic [31:0] data;
    logic [2:0]  dest;
    logic        vcv;
    logic        sag;
    logic        acc;
    logic        e_idle;
    logic        e_vcreq;
    logic        e_sareq;
    logic [3:0]  e_cnt;
    logic        e_err;
    logic        e_fvo;
    logic [2:0]  e_port;
  } vec_t;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic fv, input logic [1:0] ty, input logic [31:0] data,
                       input logic [2:0] dest, input logic vcv, input logic sag, input logic acc);
    rst              = r;
    bus.flit_valid_i = fv;
    bus.flit_type_i  = ty;
    bus.flit_data_i  = data;
    bus.dest_port_i  = dest;
    bus.vc_valid_i   = vcv;
    bus.sa_grant_i   = sag;
    if (!r) exp_q.delete();
    else if (fv && acc) exp_q.push_back({ty, data});
  endtask

  // Advance one edge, then compare any forwarded flit against the oldest expected one.
  task automatic tick(input string name);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (bus.flit_valid_o) begin
      if (exp_q.size() == 0) begin
        check({name, ".unexpected_flit"}, {bus.flit_type_o, bus.flit_data_o}, '1);
      end else begin
        e = exp_q.pop_front();
        check({name, ".flit"}, {bus.flit_type_o, bus.flit_data_o}, e);
      end
    end
  endtask

  task automatic expect_st(input string name, input logic idle, input logic vcreq, input logic sareq,
                           input logic [3:0] cnt, input logic err);
    check({name, ".idle"}, bus.idle_o, idle);
    check({name, ".vcreq"}, bus.vc_request_o, vcreq);
    check({name, ".sareq"}, bus.sa_request_o, sareq);
    check({name, ".count"}, bus.count_o, cnt);
    check({name, ".error"}, bus.error_o, err);
  endtask

  function automatic vec_t mk(input logic r, input logic fv, input logic [1:0] ty, input logic [31:0] d,
                              input logic [2:0] dest, input logic vcv, input logic sag, input logic acc,
                              input logic ei, input logic evr, input logic esr, input logic [3:0] ec,
                              input logic ee, input logic efv, input logic [2:0] ep);
    vec_t v;
    v.r = r; v.fv = fv; v.ty = ty; v.data = d; v.dest = dest; v.vcv = vcv; v.sag = sag; v.acc = acc;
    v.e_idle = ei; v.e_vcreq = evr; v.e_sareq = esr; v.e_cnt = ec; v.e_err = ee; v.e_fvo = efv;
    v.e_port = ep;
    return v;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

    // reset, HEADTAIL, 4-flit packet with long VA wait, stray grants, head+vc_valid together
    vecs.push_back(mk(0,0,2'b00,32'h0,  3'd0,0,0,0, 1,0,0,4'd0,0,0,3'd0));
    vecs.push_back(mk(0,0,2'b00,32'h0,  3'd0,0,0,0, 1,0,0,4'd0,0,0,3'd0));
    vecs.push_back(mk(1,1,2'b11,32'hA5, 3'd3,0,0,1, 0,1,0,4'd1,0,0,3'd3));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,1,0,0, 0,0,1,4'd1,0,0,3'd3));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 1,0,0,4'd0,0,1,3'd3));
    vecs.push_back(mk(1,1,2'b00,32'h100,3'd5,0,0,1, 0,1,0,4'd1,0,0,3'd5));
    vecs.push_back(mk(1,1,2'b01,32'h101,3'd0,0,0,1, 0,1,0,4'd2,0,0,3'd5));
    vecs.push_back(mk(1,1,2'b01,32'h102,3'd0,0,0,1, 0,1,0,4'd3,0,0,3'd5));
    vecs.push_back(mk(1,1,2'b10,32'h103,3'd0,0,0,1, 0,1,0,4'd4,0,0,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 0,1,0,4'd4,0,0,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,1,0,0, 0,0,1,4'd4,0,0,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 0,0,1,4'd3,0,1,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 0,0,1,4'd2,0,1,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 0,0,1,4'd1,0,1,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 1,0,0,4'd0,0,1,3'd5));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,1,1,0, 1,0,0,4'd0,0,0,3'd5));
    vecs.push_back(mk(1,1,2'b11,32'h55, 3'd2,1,0,1, 0,1,0,4'd1,0,0,3'd2));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,1,0,0, 0,0,1,4'd1,0,0,3'd2));
    vecs.push_back(mk(1,0,2'b00,32'h0,  3'd0,0,1,0, 1,0,0,4'd0,0,1,3'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      drive(vecs[i].r, vecs[i].fv, vecs[i].ty, vecs[i].data, vecs[i].dest, vecs[i].vcv, vecs[i].sag,
            vecs[i].acc);
      tick(n);
      expect_st(n, vecs[i].e_idle, vecs[i].e_vcreq, vecs[i].e_sareq, vecs[i].e_cnt, vecs[i].e_err);
      check({n, ".fvalid"}, bus.flit_valid_o, vecs[i].e_fvo);
      check({n, ".port"}, bus.out_port_o, vecs[i].e_port);
    end

    // overflow: head + 7 bodies fill the buffer, the 9th write is dropped
    drive(1, 1, 2'b00, 32'h200, 3'd1, 0, 0, 1);
    tick("full.h");
    for (int i = 1; i < 8; i++) begin
      drive(1, 1, 2'b01, 32'h200 + i, 3'd0, 0, 0, 1);
      tick("full.b");
    end
    expect_st("full.8", 0, 1, 0, 4'd8, 0);
    drive(1, 1, 2'b01, 32'h208, 3'd0, 0, 0, 0);
    tick("full.9");
    expect_st("full.9", 0, 1, 0, 4'd8, 1);
    drive(1, 0, 2'b00, 32'h0, 3'd0, 1, 0, 0);
    tick("full.vc");
    expect_st("full.vc", 0, 0, 1, 4'd8, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 2'b00, 32'h0, 3'd0, 0, 1, 0);
      tick("full.drain");
    end
    expect_st("full.drained", 0, 0, 0, 4'd0, 1);
    drive(1, 1, 2'b10, 32'h209, 3'd0, 0, 0, 1);
    tick("full.tail");
    drive(1, 0, 2'b00, 32'h0, 3'd0, 0, 1, 0);
    tick("full.tailpop");
    expect_st("full.done", 1, 0, 0, 4'd0, 1);
    drive(0, 0, 2'b00, 32'h0, 3'd0, 0, 0, 0);
    tick("rst1");
    tick("rst1b");
    expect_st("rst1", 1, 0, 0, 4'd0, 0);

    // protocol errors: BODY in IDLE, then HEAD while ACTIVE
    drive(1, 1, 2'b01, 32'h2FF, 3'd0, 0, 0, 0);
    tick("err.body");
    expect_st("err.body", 1, 0, 0, 4'd0, 1);
    check("err.body.state", bus.state_dbg, 2'd0);
    drive(0, 0, 2'b00, 32'h0, 3'd0, 0, 0, 0);
    tick("rst2");
    tick("rst2b");
    expect_st("rst2", 1, 0, 0, 4'd0, 0);
    drive(1, 1, 2'b00, 32'h300, 3'd4, 0, 0, 1);
    tick("err.h");
    drive(1, 0, 2'b00, 32'h0, 3'd0, 1, 0, 0);
    tick("err.vc");
    drive(1, 1, 2'b00, 32'h301, 3'd7, 0, 0, 0);
    tick("err.head");
    expect_st("err.head", 0, 0, 1, 4'd1, 1);
    check("err.head.state", bus.state_dbg, 2'd2);
    check("err.head.port", bus.out_port_o, 3'd4);

    // concurrent push/pop: count holds at 1 while pointers wrap past the buffer end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 2'b01, $urandom_range(32'h7FFF_FFFF, 0), 3'd0, 0, 1, 1);
      tick("pp");
      check($sformatf("pp%0d.count", i), bus.count_o, 4'd1);
      check($sformatf("pp%0d.fvalid", i), bus.flit_valid_o, 1'b1);
    end
    drive(1, 1, 2'b10, 32'h3FF, 3'd0, 0, 1, 1);
    tick("pp.tail");
    expect_st("pp.tail", 0, 0, 1, 4'd1, 1);
    drive(1, 0, 2'b00, 32'h0, 3'd0, 0, 1, 0);
    tick("pp.tailpop");
    expect_st("pp.done", 1, 0, 0, 4'd0, 1);

    // reset in the middle of a packet discards buffered flits
    drive(1, 1, 2'b00, 32'h400, 3'd6, 0, 0, 1);
    tick("mid.h");
    drive(1, 1, 2'b01, 32'h401, 3'd0, 0, 0, 1);
    tick("mid.b");
    drive(1, 0, 2'b00, 32'h0, 3'd0, 1, 0, 0);
    tick("mid.vc");
    expect_st("mid.pre", 0, 0, 1, 4'd2, 1);
    drive(0, 0, 2'b00, 32'h0, 3'd0, 0, 1, 0);
    tick("mid.rst");
    expect_st("mid.rst", 1, 0, 0, 4'd0, 0);
    check("mid.rst.fvalid", bus.flit_valid_o, 1'b0);
    check("mid.rst.port", bus.out_port_o, 3'd0);
    drive(1, 0, 2'b00, 32'h0, 3'd0, 0, 1, 0);
    tick("mid.after");
    expect_st("mid.after", 1, 0, 0, 4'd0, 0);
    check("mid.after.fvalid", bus.flit_valid_o, 1'b0);

    check("scoreboard.empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/input_vc_controller.md
Name: input_vc_controller

Overview:
- Downstream-side controller for one input-port virtual channel.
- Buffers incoming flits, requests VC allocation for each packet's head, and forwards flits on switch grants.
- Drives the idle indication that upstream VC allocators consume as `idle_downstream_vc_i`.
- One instance per input port of the router.

Parameters:
BUFFER_SIZE, 8, flit FIFO depth; must be a power of two and at least 2.
FLIT_DATA, 32, payload width in bits.
PORT_SIZE, 3, width of the routed output-port field.

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  synchronous reset, active-low; sampled on rising clk
flit_valid_i  input  1  flit write strobe from upstream link
flit_type_i  input  2  flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL
flit_data_i  input  FLIT_DATA  flit payload
dest_port_i  input  PORT_SIZE  routed output port, meaningful with HEAD/HEADTAIL only
vc_request_o  output  1  VC allocation request to the local allocator
out_port_o  output  PORT_SIZE  latched output port of the current packet
vc_valid_i  input  1  VC allocation grant
sa_request_o  output  1  switch allocation request
sa_grant_i  input  1  switch grant; pops one flit
flit_valid_o  output  1  forwarded flit valid
flit_type_o  output  2  forwarded flit type
flit_data_o  output  FLIT_DATA  forwarded flit payload
idle_o  output  1  VC holds no packet; drives upstream `idle_downstream_vc_i`
count_o  output  $clog2(BUFFER_SIZE)+1  FIFO occupancy
error_o  output  1  sticky protocol-error flag

Behaviour:
Reset (rst == 0 at a rising edge):
- state = IDLE; FIFO pointers and count = 0.
- idle_o = 1, matching the upstream allocator's reset value of "available".
- All other outputs are 0.
- Reset has priority over every other event. Reset mid-packet discards the buffer contents.

FSM states:
- IDLE: no packet.
- VA: head buffered, awaiting VC grant.
- ACTIVE: VC granted, forwarding flits.

Transitions:
- IDLE -> VA: accepted write of HEAD or HEADTAIL. out_port_o latches dest_port_i on the same edge.
- VA -> ACTIVE: vc_valid_i == 1.
- ACTIVE -> IDLE: sa_grant_i pops the entry whose type is TAIL or HEADTAIL.
- vc_valid_i is ignored in IDLE and ACTIVE.

Write acceptance:
- A flit is accepted when flit_valid_i == 1, count < BUFFER_SIZE, and the type is legal for the state.
- HEAD/HEADTAIL is legal only in IDLE with count == 0.
- BODY/TAIL is legal only in VA or ACTIVE, and only before the packet's tail has been written. A flag is set on tail write and cleared on return to IDLE.
- Illegal or overflowing writes are dropped and set error_o; error_o clears only on reset.

FIFO:
- Circular buffer; pointers wrap modulo BUFFER_SIZE.
- Simultaneous push and pop leave count unchanged.
- Pop on empty cannot happen because sa_request_o gates it. A stray sa_grant_i with sa_request_o == 0 is ignored.

Outputs:
- vc_request_o = (state == VA), registered. It asserts the cycle after the head write and holds until the grant edge.
- sa_request_o = (state == ACTIVE) && (count != 0), combinational from registered state and count.
- Forwarding latency is 1 cycle: on the edge where sa_grant_i && sa_request_o, the oldest entry is registered into flit_type_o/flit_data_o and flit_valid_o = 1.
- Otherwise flit_valid_o = 0 and flit_type_o/flit_data_o hold their last values.
- idle_o is registered: it is 1 when next state is IDLE and next count is 0.
  - It falls the cycle after a head is accepted.
  - It rises the cycle after the tail pop edge.
  - Hence the tail's flit_valid_o and the rise of idle_o coincide.
- count_o is the registered count.

Simultaneous events:
- Head write and vc_valid_i in the same cycle in IDLE: the grant is ignored; the FSM goes to VA.
- In ACTIVE, BODY/TAIL pushes concurrent with pops are allowed.
- Tail pop with count == 1 returns to IDLE with count = 0.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles -> idle_o = 1, vc_request_o = 0, sa_request_o = 0, count_o = 0, error_o = 0.
2. Single HEADTAIL flit:
   - Stimulus: write data 0xA5, dest_port_i = 3; grant VC next cycle; then grant switch.
   - Response: idle_o falls one cycle after the write; vc_request_o = 1 for one cycle; out_port_o = 3.
   - Flit 0xA5, type 11, appears with flit_valid_o one cycle after sa_grant_i; idle_o = 1 that same cycle.
3. 4-flit packet (H, B, B, T) written back-to-back while VA waits 5 cycles:
   - count_o reaches 4; sa_request_o = 0 until the grant.
   - After grant, 4 consecutive sa_grant_i produce flits in order, then the FSM returns to IDLE.
4. Full buffer: BUFFER_SIZE = 8, write 9 flits before any pop -> count_o = 8, 9th dropped, error_o = 1 and sticky.
5. Protocol errors:
   - BODY in IDLE -> dropped, error_o = 1.
   - HEAD while ACTIVE -> dropped; state and count unchanged.
6. Concurrent push/pop and reset:
   - In ACTIVE, push BODY and pop each cycle for 10 cycles -> count_o constant; pointers wrap correctly.
   - Assert rst = 0 mid-packet -> next cycle idle_o = 1, count_o = 0.
